// File: rtl/toymips_pkg.sv
// Shared definitions for the toyMIPS fetch path: FSM encoding and fetch constants.
package toymips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FULL = 2'd2
    } fetch_state_e;

    localparam logic [7:0] PC_STEP = 8'd4;
    localparam int         INSTR_W = 32;

endpackage

// File: rtl/branch_resolve.sv
// Combinational beq/bne decision, jump/branch target select and word alignment.
module branch_resolve #(
    parameter int AW = 8
) (
    input  logic          is_beq,
    input  logic          is_bne,
    input  logic          alu_zero,
    input  logic [AW-1:0] branch_target,
    input  logic          jump_en,
    input  logic [AW-1:0] jump_target,
    output logic          redirect,
    output logic [AW-1:0] target
);

    logic          branch_taken;
    logic [AW-1:0] sel;

    always_comb begin
        branch_taken = (is_beq & alu_zero) | (is_bne & ~alu_zero);
        redirect     = jump_en | branch_taken;
        // Jump outranks a simultaneously resolved branch.
        sel          = jump_en ? jump_target : branch_target;
        target       = sel & ~AW'(3);
    end

endmodule

// File: rtl/pc_fetch_seq.sv
// PC register and ack-handshaked instruction fetch FSM presenting one instruction to decode.
module pc_fetch_seq
    import toymips_pkg::*;
#(
    parameter int          AW       = 8,
    parameter logic [AW-1:0] RESET_PC = 8'h00
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               is_beq,
    input  logic               is_bne,
    input  logic               alu_zero,
    input  logic [AW-1:0]      branch_target,
    input  logic               jump_en,
    input  logic [AW-1:0]      jump_target,
    input  logic               stall,
    output logic               imem_req,
    output logic [AW-1:0]      imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [AW-1:0]      instr_pc,
    output logic [AW-1:0]      pc_plus4
);

    fetch_state_e       state, state_d;
    logic [AW-1:0]      pc, pc_d;
    logic [AW-1:0]      pending_pc, pending_pc_d;
    logic               discard, discard_d;
    logic               req_d, valid_d;
    logic [AW-1:0]      addr_d, instr_pc_d;
    logic [INSTR_W-1:0] instr_d;

    logic               redirect;
    logic [AW-1:0]      target;

    branch_resolve #(.AW(AW)) u_branch_resolve (
        .is_beq        (is_beq),
        .is_bne        (is_bne),
        .alu_zero      (alu_zero),
        .branch_target (branch_target),
        .jump_en       (jump_en),
        .jump_target   (jump_target),
        .redirect      (redirect),
        .target        (target)
    );

    assign pc_plus4 = instr_pc + PC_STEP;

    always_comb begin
        state_d      = state;
        pc_d         = pc;
        pending_pc_d = pending_pc;
        discard_d    = discard;
        req_d        = imem_req;
        addr_d       = imem_addr;
        valid_d      = instr_valid;
        instr_d      = instr;
        instr_pc_d   = instr_pc;

        case (state)
            IDLE: begin
                state_d = REQ;
                req_d   = 1'b1;
            end
            REQ: begin
                if (imem_ack) begin
                    if (redirect) begin
                        pc_d      = target;
                        discard_d = 1'b0;
                    end else if (discard) begin
                        pc_d      = pending_pc;
                        discard_d = 1'b0;
                    end else begin
                        instr_d    = imem_rdata;
                        instr_pc_d = pc;
                        valid_d    = 1'b1;
                        pc_d       = pc + PC_STEP;
                        req_d      = 1'b0;
                        state_d    = FULL;
                    end
                end else if (redirect) begin
                    // Request already in flight: remember where to go once it returns.
                    discard_d    = 1'b1;
                    pending_pc_d = target;
                end
            end
            FULL: begin
                if (redirect) begin
                    valid_d = 1'b0;
                    pc_d    = target;
                    req_d   = 1'b1;
                    state_d = REQ;
                end else if (!stall) begin
                    valid_d = 1'b0;
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase

        // The address register follows the PC only while a request is being issued.
        if (state_d == REQ) begin
            addr_d = pc_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            pending_pc  <= '0;
            discard     <= 1'b0;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else begin
            state       <= state_d;
            pc          <= pc_d;
            pending_pc  <= pending_pc_d;
            discard     <= discard_d;
            imem_req    <= req_d;
            imem_addr   <= addr_d;
            instr_valid <= valid_d;
            instr       <= instr_d;
            instr_pc    <= instr_pc_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Directed bench for pc_fetch_seq: fetch cadence, stall, redirects, wrap and async reset.
module tb_pc_fetch_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        is_beq, is_bne, alu_zero, jump_en, stall, imem_ack;
    logic [7:0]  branch_target, jump_target;
    logic        imem_req, instr_valid;
    logic [7:0]  imem_addr, instr_pc, pc_plus4;
    logic [31:0] imem_rdata, instr;

    int compared   = 0;
    int mismatched = 0;

    pc_fetch_seq #(.AW(8), .RESET_PC(8'h00)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .is_beq        (is_beq),
        .is_bne        (is_bne),
        .alu_zero      (alu_zero),
        .branch_target (branch_target),
        .jump_en       (jump_en),
        .jump_target   (jump_target),
        .stall         (stall),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .pc_plus4      (pc_plus4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_redirect();
        is_beq = 0; is_bne = 0; alu_zero = 0; jump_en = 0;
        branch_target = 8'h00; jump_target = 8'h00;
    endtask

    initial begin
        rst_n = 0; stall = 0; imem_ack = 0; imem_rdata = 32'h0;
        clear_redirect();
        tick(); tick();

        // Reset values
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_addr", {24'b0, imem_addr}, 32'h00);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_ipc", {24'b0, instr_pc}, 32'h00);
        check("rst_pc4", {24'b0, pc_plus4}, 32'h04);

        rst_n = 1;
        tick();
        check("req0_req", {31'b0, imem_req}, 32'd1);
        check("req0_addr", {24'b0, imem_addr}, 32'h00);

        imem_ack = 1; imem_rdata = 32'h1234_5678;
        tick();
        check("f0_valid", {31'b0, instr_valid}, 32'd1);
        check("f0_instr", instr, 32'h1234_5678);
        check("f0_ipc", {24'b0, instr_pc}, 32'h00);
        check("f0_pc4", {24'b0, pc_plus4}, 32'h04);
        check("f0_req", {31'b0, imem_req}, 32'd0);

        tick();  // ack held high in FULL is ignored
        check("req1_addr", {24'b0, imem_addr}, 32'h04);
        check("req1_valid", {31'b0, instr_valid}, 32'd0);
        tick();
        check("f1_valid", {31'b0, instr_valid}, 32'd1);
        check("f1_ipc", {24'b0, instr_pc}, 32'h04);
        check("f1_pc4", {24'b0, pc_plus4}, 32'h08);

        // Stall for three cycles
        imem_ack = 0; stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", {31'b0, instr_valid}, 32'd1);
            check("stall_ipc", {24'b0, instr_pc}, 32'h04);
            check("stall_instr", instr, 32'h1234_5678);
            check("stall_req", {31'b0, imem_req}, 32'd0);
        end
        stall = 0;
        tick();
        check("unstall_addr", {24'b0, imem_addr}, 32'h08);
        check("unstall_req", {31'b0, imem_req}, 32'd1);

        // Redirect while request to 08 outstanding, ack three cycles later
        is_beq = 1; alu_zero = 1; branch_target = 8'h20;
        tick();
        clear_redirect();
        check("pend_addr", {24'b0, imem_addr}, 32'h08);
        tick(); tick();
        check("pend_addr2", {24'b0, imem_addr}, 32'h08);
        imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        check("disc_valid", {31'b0, instr_valid}, 32'd0);
        check("disc_addr", {24'b0, imem_addr}, 32'h20);
        check("disc_req", {31'b0, imem_req}, 32'd1);
        imem_rdata = 32'hAAAA_0001;
        tick();
        imem_ack = 0;
        check("f20_valid", {31'b0, instr_valid}, 32'd1);
        check("f20_ipc", {24'b0, instr_pc}, 32'h20);
        check("f20_instr", instr, 32'hAAAA_0001);

        // bne with zero set: no redirect, stall holds
        is_bne = 1; alu_zero = 1; branch_target = 8'h40; stall = 1;
        tick();
        check("bne_valid", {31'b0, instr_valid}, 32'd1);
        check("bne_ipc", {24'b0, instr_pc}, 32'h20);
        check("bne_req", {31'b0, imem_req}, 32'd0);
        // beq taken flushes even under stall
        is_bne = 0; is_beq = 1;
        tick();
        clear_redirect(); stall = 0;
        check("flush_valid", {31'b0, instr_valid}, 32'd0);
        check("flush_req", {31'b0, imem_req}, 32'd1);
        check("flush_addr", {24'b0, imem_addr}, 32'h40);

        // Jump + taken branch + ack together: jump wins, data dropped
        jump_en = 1; jump_target = 8'h80;
        is_beq = 1; alu_zero = 1; branch_target = 8'h40;
        imem_ack = 1; imem_rdata = 32'hBAD0_BAD0;
        tick();
        clear_redirect(); imem_ack = 0;
        check("jb_valid", {31'b0, instr_valid}, 32'd0);
        check("jb_addr", {24'b0, imem_addr}, 32'h80);
        check("jb_instr", instr, 32'hAAAA_0001);

        // Misaligned jump to FE lands on FC; then wrap
        jump_en = 1; jump_target = 8'hFE;
        tick();
        clear_redirect();
        imem_ack = 1;
        tick();
        check("fc_addr", {24'b0, imem_addr}, 32'hFC);
        check("fc_valid", {31'b0, instr_valid}, 32'd0);
        imem_rdata = 32'h0000_00FC;
        tick();
        imem_ack = 0;
        check("wrap_ipc", {24'b0, instr_pc}, 32'hFC);
        check("wrap_pc4", {24'b0, pc_plus4}, 32'h00);
        tick();
        check("wrap_addr", {24'b0, imem_addr}, 32'h00);

        // Branch target 43 is issued as 40
        is_beq = 1; alu_zero = 1; branch_target = 8'h43; imem_ack = 1;
        tick();
        clear_redirect(); imem_ack = 0;
        check("align_addr", {24'b0, imem_addr}, 32'h40);
        check("align_req", {31'b0, imem_req}, 32'd1);

        // Asynchronous reset with request outstanding
        #1 rst_n = 0;
        #1;
        check("arst_req", {31'b0, imem_req}, 32'd0);
        check("arst_addr", {24'b0, imem_addr}, 32'h00);
        check("arst_valid", {31'b0, instr_valid}, 32'd0);
        check("arst_instr", instr, 32'h0);
        check("arst_ipc", {24'b0, instr_pc}, 32'h00);
        check("arst_pc4", {24'b0, pc_plus4}, 32'h04);
        tick();
        rst_n = 1;
        tick();
        check("restart_req", {31'b0, imem_req}, 32'd1);
        check("restart_addr", {24'b0, imem_addr}, 32'h00);
        imem_ack = 1; imem_rdata = 32'h5555_AAAA;
        tick();
        imem_ack = 0;
        check("restart_valid", {31'b0, instr_valid}, 32'd1);
        check("restart_ipc", {24'b0, instr_pc}, 32'h00);
        check("restart_instr", instr, 32'h5555_AAAA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
